// File: rtl/rr_arb_onehot_pkg.sv
// Shared defaults and width helper for the round-robin one-hot arbiter.
package rr_arb_onehot_pkg;

  localparam int unsigned DefaultNumIn     = 4;
  localparam int unsigned DefaultDataWidth = 32;

  // Index width for n entries; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot0 to binary encoder; all-zero input encodes to zero.
module onehot_to_bin
  import rr_arb_onehot_pkg::*;
#(
  parameter int unsigned ONEHOT_WIDTH = DefaultNumIn,
  parameter int unsigned BIN_WIDTH    = idx_width(ONEHOT_WIDTH)
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic [BIN_WIDTH-1:0]    bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot_i[i]) begin
        bin_o = bin_o | BIN_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arb_onehot.sv
// Round-robin arbiter with rotating priority pointer, one-hot and binary winner
// outputs, and an optional lock that freezes the winner while the output stalls.
module rr_arb_onehot
  import rr_arb_onehot_pkg::*;
#(
  parameter int unsigned NumIn     = DefaultNumIn,
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter bit          LockIn    = 1'b1,
  parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [NumIn-1:0]                req_i,
  output logic [NumIn-1:0]                gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0] data_i,
  output logic                            req_o,
  input  logic                            gnt_i,
  output logic [DataWidth-1:0]            data_o,
  output logic [NumIn-1:0]                onehot_o,
  output logic [IdxWidth-1:0]             idx_o
);

  logic [IdxWidth-1:0] r_rr;
  logic                r_lock;
  logic [NumIn-1:0]    r_sel;

  logic [NumIn-1:0]    w_req_rot;
  logic [NumIn-1:0]    w_first_rot;
  logic [NumIn-1:0]    w_arb;
  logic [NumIn-1:0]    w_onehot;
  logic [IdxWidth-1:0] w_idx;
  logic [IdxWidth-1:0] w_rr_next;
  logic                w_req_any;

  // Rotate so the pointer input sits at bit 0, keep the lowest set bit, rotate back.
  assign w_req_rot   = (req_i >> r_rr) | (req_i << (NumIn - 32'(r_rr)));
  assign w_first_rot = w_req_rot & (~w_req_rot + NumIn'(1));
  assign w_arb       = (w_first_rot << r_rr) | (w_first_rot >> (NumIn - 32'(r_rr)));

  assign w_req_any = |req_i;
  assign w_onehot  = (r_lock ? r_sel : w_arb) & {NumIn{w_req_any}};

  assign req_o    = w_req_any;
  assign onehot_o = w_onehot;
  assign gnt_o    = w_onehot & {NumIn{gnt_i}};
  assign idx_o    = w_idx;

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (w_onehot[i]) begin
        data_o = data_o | data_i[i];
      end
    end
  end

  onehot_to_bin #(
    .ONEHOT_WIDTH (NumIn),
    .BIN_WIDTH    (IdxWidth)
  ) u_onehot_to_bin (
    .onehot_i (w_onehot),
    .bin_o    (w_idx)
  );

  // Explicit wrap keeps the pointer in range for non-power-of-two NumIn.
  assign w_rr_next = (w_idx == IdxWidth'(NumIn - 1)) ? '0 : w_idx + IdxWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr   <= '0;
      r_lock <= 1'b0;
      r_sel  <= '0;
    end else if (flush_i) begin
      r_rr   <= '0;
      r_lock <= 1'b0;
    end else if (w_req_any && gnt_i) begin
      r_rr   <= w_rr_next;
      r_lock <= 1'b0;
    end else if (w_req_any && LockIn) begin
      r_lock <= 1'b1;
      r_sel  <= w_onehot;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_lock_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_lock |-> ((req_i & r_sel) == r_sel));
  a_lock_data : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_lock |-> $stable(data_o));
`endif

endmodule
